// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read ports and sweep-clear control.
// The master side drives requests and indices; the slave side returns read data and status.
interface reg_file_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_reg1;
    logic [ADDR_WIDTH-1:0] read_reg2;
    logic                  clear;
    logic [DATA_WIDTH-1:0] reg_out1;
    logic [DATA_WIDTH-1:0] reg_out2;
    logic                  valid1;
    logic                  valid2;
    logic                  busy;
    logic                  write_ack;

    modport master (
        output write_en, write_reg, write_data, read_reg1, read_reg2, clear,
        input  reg_out1, reg_out2, valid1, valid2, busy, write_ack
    );

    modport slave (
        input  write_en, write_reg, write_data, read_reg1, read_reg2, clear,
        output reg_out1, reg_out2, valid1, valid2, busy, write_ack
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterised register file: one write port, two combinational read ports, per-register
// valid bits and a one-register-per-cycle clear sweep. Optional macro: REG_FILE_BYPASS_EN.
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    reg_file_param_if.slave   bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_idx_nxt;
    logic                  w_wr_acc;
    logic                  r_wack;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_valid;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic                  w_v1;
    logic                  w_v2;

    // State and sweep index registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic; CLEAR beats a simultaneous write and is ignored mid-sweep
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_acc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = ST_SWEEP;
                    w_idx_nxt   = '0;
                end else begin
                    w_wr_acc    = bus.write_en;
                end
            end
            ST_SWEEP: begin
                w_idx_nxt = r_idx + IDX_ONE;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Storage, valid bits and the write acknowledge pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_valid <= '0;
            r_wack  <= 1'b0;
        end else begin
            r_wack <= w_wr_acc;
            if (w_wr_acc) begin
                r_regs[bus.write_reg]  <= bus.write_data;
                r_valid[bus.write_reg] <= 1'b1;
            end else if (r_state == ST_SWEEP) begin
                r_regs[r_idx]  <= '0;
                r_valid[r_idx] <= 1'b0;
            end
        end
    end

    // Combinational read ports, optionally forwarding an about-to-be-accepted write
    always_comb begin
        w_rd1 = r_regs[bus.read_reg1];
        w_v1  = r_valid[bus.read_reg1];
        w_rd2 = r_regs[bus.read_reg2];
        w_v2  = r_valid[bus.read_reg2];
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_acc && i_rst_n && (bus.read_reg1 == bus.write_reg)) begin
            w_rd1 = bus.write_data;
            w_v1  = 1'b1;
        end else begin
            w_rd1 = r_regs[bus.read_reg1];
            w_v1  = r_valid[bus.read_reg1];
        end
        if (w_wr_acc && i_rst_n && (bus.read_reg2 == bus.write_reg)) begin
            w_rd2 = bus.write_data;
            w_v2  = 1'b1;
        end else begin
            w_rd2 = r_regs[bus.read_reg2];
            w_v2  = r_valid[bus.read_reg2];
        end
`endif
    end

    assign bus.reg_out1  = w_rd1;
    assign bus.reg_out2  = w_rd2;
    assign bus.valid1    = w_v1;
    assign bus.valid2    = w_v2;
    assign bus.busy      = (r_state == ST_SWEEP);
    assign bus.write_ack = r_wack;

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of each register.
REQ-002 Parameter NUM_REGS, default 8, SHALL set the register count; it SHALL be a power of two and at least 2.
REQ-003 Local parameter ADDR_WIDTH SHALL equal clog2(NUM_REGS), which is 3 by default.
REQ-004 CLOCK  input  1  SHALL be the single clock; all state SHALL change on its rising edge, except on reset.
REQ-005 RESET  input  1  SHALL be the reset: asynchronous and active-low.
REQ-006 WRITEENABLE  input  1  SHALL request a write at the next rising edge.
REQ-007 WRITEREG  input  ADDR_WIDTH  SHALL give the write register index.
REQ-008 WRITEDATA  input  DATA_WIDTH  SHALL give the write data.
REQ-009 READREG1, READREG2  input  ADDR_WIDTH  SHALL give the read port indices.
REQ-010 REGOUT1, REGOUT2  output  DATA_WIDTH  SHALL carry the read port data.
REQ-011 VALID1, VALID2  output  1  SHALL flag that the addressed register has been written since its last reset or clear.
REQ-012 CLEAR  input  1  SHALL request a sequential clear sweep.
REQ-013 BUSY  output  1  SHALL be high while a sweep is in progress.
REQ-014 WRITEACK  output  1  SHALL be a registered pulse, high for the one cycle after an accepted write.

Function
REQ-015 Reads SHALL be combinational: REGOUTn = reg[READREGn] and VALIDn = valid[READREGn], both settling within the same cycle.
REQ-016 A write SHALL be accepted when WRITEENABLE=1, the state is IDLE and CLEAR=0, all sampled at the rising edge.
REQ-017 An accepted write SHALL set reg[WRITEREG] to WRITEDATA and valid[WRITEREG] to 1 at that edge.
REQ-018 An accepted write SHALL cause WRITEACK=1 for the following cycle; otherwise WRITEACK SHALL be 0.
REQ-019 The FSM SHALL have two states, IDLE and SWEEP, and a sweep index of ADDR_WIDTH bits.
REQ-020 IDLE SHALL move to SWEEP at a rising edge with CLEAR=1, with the index set to 0.
REQ-021 In SWEEP, each rising edge SHALL zero reg[index] and valid[index], then increment the index.
REQ-022 The edge that clears index NUM_REGS-1 SHALL return the FSM to IDLE, so BUSY is high for exactly NUM_REGS cycles.
REQ-023 BUSY SHALL be 1 if and only if the state is SWEEP.
REQ-024 CLEAR asserted during SWEEP SHALL be ignored and SHALL NOT restart the sweep.
REQ-025 Simultaneous WRITEENABLE and CLEAR in IDLE: CLEAR SHALL win, the write SHALL be dropped and WRITEACK SHALL stay 0.
REQ-026 WRITEENABLE during SWEEP SHALL be dropped with no state change and WRITEACK=0; the requester SHALL retry.
REQ-027 Reads during SWEEP SHALL be permitted and SHALL return the current contents, with registers already swept reading 0 with VALID=0.
REQ-028 Both read ports addressing the same register SHALL return identical data.
REQ-029 Write indices SHALL need no range check, since every index value is in range.

Reset
REQ-030 RESET=0 SHALL immediately, independent of CLOCK, zero all registers and valid bits, force IDLE, and zero the sweep index, BUSY and WRITEACK.
REQ-031 While RESET=0, REGOUT1/2 SHALL read 0, VALID1/2 SHALL be 0, and writes and CLEAR SHALL be ignored.
REQ-032 A reset asserted mid-sweep SHALL abort the sweep, leaving IDLE with all registers zero after release.

Configuration
REQ-033 Macro REG_FILE_BYPASS_EN, when defined, SHALL make a read port whose READREGn equals WRITEREG return WRITEDATA with VALIDn=1 combinationally, whenever the write would be accepted per REQ-016.
REQ-034 Without REG_FILE_BYPASS_EN, the same read SHALL return the stored old value and valid bit until the write edge.

Verification
REQ-035 Reset, then write 7 to reg 1 and read ports 0 and 1 -> REGOUT1=0 with VALID1=0, REGOUT2=7 with VALID2=1, and WRITEACK high for 1 cycle.
REQ-036 Write 12 to reg 6, then set WRITEENABLE=0 and WRITEDATA=99 -> reg 6 reads 12 and reg 1 still reads 7.
REQ-037 Fill all 8 registers with 0xA0+i, pulse CLEAR, and issue a write to reg 3 during the sweep -> BUSY high for exactly 8 cycles, the write is dropped, and afterwards all registers read 0 with VALID=0.
REQ-038 Assert CLEAR and WRITEENABLE in the same IDLE cycle -> the sweep starts and WRITEACK=0.
REQ-039 Drop RESET mid-sweep at index 4 -> BUSY falls immediately and all outputs are 0.
REQ-040 Read reg 2 while writing 0x55 to reg 2 -> 0x55 before the edge with REG_FILE_BYPASS_EN defined, the old value without it; repeat at DATA_WIDTH=16 and NUM_REGS=32.
